pmem_arbiter: RTL and testbench
===============================

Name: pmem_arbiter

Overview:
Shares the single 256-bit physical-memory line port between the instruction cache and the data cache. Each cache presents a level-sensitive line read (I and D) or line write (D only) request and holds it until its one-cycle resp. The arbiter grants one requester at a time and routes the response back to it. It sits between both caches and the memory/burst interface. It also provides round-robin or D-priority arbitration and a transaction watchdog.

Parameters:
LINE_W, 256, line width in bits
ADDR_W, 32, address width
RR_EN, 1, 1 = round-robin on simultaneous requests; 0 = D always wins
WDOG_CYCLES, 4096, max cycles a granted transaction may wait for pmem_resp before err is flagged

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
i_address  in  ADDR_W  icache line address, 32-byte aligned
i_read  in  1  icache line read request
i_rdata  out  LINE_W  read line to icache
i_resp  out  1  icache transaction done, one-cycle pulse
d_address  in  ADDR_W  dcache line address
d_read  in  1  dcache line read request
d_write  in  1  dcache line write (writeback) request
d_wdata  in  LINE_W  dcache writeback line
d_rdata  out  LINE_W  read line to dcache
d_resp  out  1  dcache transaction done, one-cycle pulse
pmem_address  out  ADDR_W  memory address
pmem_rdata  in  LINE_W  memory read line
pmem_wdata  out  LINE_W  memory write line
pmem_read  out  1  memory read request
pmem_write  out  1  memory write request
pmem_resp  in  1  memory done, one-cycle pulse
err  out  1  sticky watchdog error

Behaviour:
- Reset (rst=0, async): state=IDLE, last_grant=D, pmem_read=pmem_write=0, pmem_address=0, pmem_wdata=0, i_resp=d_resp=0, err=0, wdog=0.
- States: IDLE, BUSY_I, BUSY_D, GAP.
- IDLE, I requests only (i_read): latch i_address, set pmem_read=1 at next edge, go to BUSY_I.
- IDLE, D requests only (d_read|d_write): latch d_address, d_wdata and the op, go to BUSY_D.
- If d_read and d_write are both high, write takes priority.
- IDLE, both request: with RR_EN=1, grant the requester opposite last_grant. With RR_EN=0, grant D.
- On every grant, last_grant updates to the granted requester.
- Grant latency: request seen in IDLE at edge N, so pmem_read/pmem_write are high from N+1.
- pmem_address, pmem_wdata, pmem_read and pmem_write are registered. They stay stable for the whole transaction, independent of requester inputs.
- BUSY_x while pmem_resp=0: hold all outputs; wdog increments, saturating at WDOG_CYCLES.
- BUSY_x on pmem_resp=1 (same cycle, combinational):
  - x_resp=1 for exactly that cycle; x_rdata=pmem_rdata.
  - The other resp stays 0; its rdata is don't-care.
  - pmem_read/pmem_write deassert at the next edge; go to GAP; wdog clears.
- GAP: exactly one cycle, then IDLE. Requests are ignored here, because a cache may still hold read high for one cycle after its resp.
- A request pending in GAP is granted in IDLE one cycle later: turnaround from resp to the next pmem request is 2 cycles.
- Watchdog: if wdog reaches WDOG_CYCLES-1 without pmem_resp, err goes to 1 and stays sticky until reset. The transaction keeps waiting; it is not aborted.
- A requester dropping its request mid-transaction is illegal. The memory transaction still completes, and resp still pulses to that requester.
- pmem_resp outside BUSY_x is ignored; no resp is generated.
- Reset mid-transaction: outputs drop immediately (async), and the pending response is lost.
- i_resp and d_resp are never high in the same cycle. pmem_read and pmem_write are never high together.

Test Plan:
- Single I read: i_read=1, i_address=0x0000_1040; memory resps after 10 cycles with rdata=0xA5..A5 -> pmem_read high from cycle+1 with address 0x1040; i_resp=1 one cycle, i_rdata=0xA5..A5; d_resp stays 0.
- Single D writeback: d_write=1, d_address=0x8000_0020, d_wdata=0x1234..; memory resps after 5 cycles -> pmem_write=1, pmem_wdata=0x1234.., pmem_read=0; d_resp one cycle.
- Simultaneous requests: i_read and d_read high together after reset, RR_EN=1 -> I granted first (last_grant=D). After I resp, GAP, then D granted 2 cycles after i_resp. Repeat the pattern and confirm grants alternate I, D, I, D. With RR_EN=0, D always wins.
- Sticky request after resp: i_read held one cycle past i_resp -> no second transaction in GAP. If i_read is dropped in GAP, pmem_read stays 0 thereafter.
- Watchdog: WDOG_CYCLES=16, memory never responds -> err=1 at the 16th busy cycle and pmem_read remains 1. A late pmem_resp completes the transaction, and err stays 1.
- Reset mid-transaction: rst=0 while BUSY_D is waiting -> pmem_write=0 within the same cycle. After release, state is IDLE, err=0, and a new i_read is granted normally.

Source files
------------

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares one physical-memory line port between the icache (read
// only) and the dcache (read/writeback). Only one transaction is in flight at a
// time. Simultaneous requests are resolved round-robin, or in favour of the
// dcache when round-robin is disabled. A watchdog raises a sticky error flag
// when memory takes too long to respond.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   i_address/i_read              icache line read request
//   i_rdata/i_resp                icache read line and one-cycle done pulse
//   d_address/d_read/d_write      dcache line request (write wins over read)
//   d_wdata                       dcache writeback line
//   d_rdata/d_resp                dcache read line and one-cycle done pulse
//   pmem_address/pmem_wdata       registered memory address and write line
//   pmem_read/pmem_write          registered memory request strobes
//   pmem_rdata/pmem_resp          memory read line and done pulse
//   err                           sticky watchdog error
module pmem_arbiter #(
  parameter int unsigned LINE_W      = 256,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned RR_EN       = 1,
  parameter int unsigned WDOG_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_address,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] pmem_address,
  input  logic [LINE_W-1:0] pmem_rdata,
  output logic [LINE_W-1:0] pmem_wdata,
  output logic              pmem_read,
  output logic              pmem_write,
  input  logic              pmem_resp,
  output logic              err
);

  localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    GAP    = 2'd3
  } state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  state_t              state, state_next;
  grant_t              last_grant, last_grant_next;
  logic [ADDR_W-1:0]   address_next;
  logic [LINE_W-1:0]   wdata_next;
  logic                read_next, write_next;
  logic [WDOG_W-1:0]   wdog, wdog_next, wdog_inc;
  logic                err_next;
  logic                i_req, d_req, grant_i;

  // Both caches see the memory line directly; only the resp pulse qualifies it.
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

  // State and registered memory-side outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      last_grant   <= GRANT_D;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      wdog         <= '0;
      err          <= 1'b0;
    end else begin
      state        <= state_next;
      last_grant   <= last_grant_next;
      pmem_address <= address_next;
      pmem_wdata   <= wdata_next;
      pmem_read    <= read_next;
      pmem_write   <= write_next;
      wdog         <= wdog_next;
      err          <= err_next;
    end
  end

  // Arbitration, transaction sequencing, watchdog and response routing.
  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    address_next    = pmem_address;
    wdata_next      = pmem_wdata;
    read_next       = pmem_read;
    write_next      = pmem_write;
    wdog_next       = wdog;
    err_next        = err;
    i_resp          = 1'b0;
    d_resp          = 1'b0;

    i_req    = i_read;
    d_req    = d_read | d_write;
    // I wins when alone, or on a tie when round-robin says it is I's turn.
    grant_i  = i_req && (!d_req || ((RR_EN != 0) && (last_grant == GRANT_D)));
    wdog_inc = (wdog == WDOG_W'(WDOG_CYCLES)) ? wdog : wdog + WDOG_W'(1);

    case (state)
      IDLE: begin
        if (grant_i) begin
          state_next      = BUSY_I;
          last_grant_next = GRANT_I;
          address_next    = i_address;
          read_next       = 1'b1;
          write_next      = 1'b0;
          wdog_next       = '0;
        end else if (d_req) begin
          state_next      = BUSY_D;
          last_grant_next = GRANT_D;
          address_next    = d_address;
          wdata_next      = d_wdata;
          read_next       = ~d_write;
          write_next      = d_write;
          wdog_next       = '0;
        end
      end

      BUSY_I, BUSY_D: begin
        if (pmem_resp) begin
          i_resp     = (state == BUSY_I);
          d_resp     = (state == BUSY_D);
          state_next = GAP;
          read_next  = 1'b0;
          write_next = 1'b0;
          wdog_next  = '0;
        end else begin
          wdog_next = wdog_inc;
          // Flag as the counter reaches WDOG_CYCLES-1; the transaction keeps waiting.
          if (wdog_inc >= WDOG_W'(WDOG_CYCLES - 1)) begin
            err_next = 1'b1;
          end
        end
      end

      // One dead cycle so a cache still holding its request after resp is not re-granted.
      GAP: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
module tb_pmem_arbiter;

  localparam int unsigned LINE_W = 256;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned WDOG   = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] i_address, d_address;
  logic              i_read, d_read, d_write;
  logic [LINE_W-1:0] d_wdata, pmem_rdata;
  logic              pmem_resp;

  logic [LINE_W-1:0] i_rdata, d_rdata, pmem_wdata;
  logic              i_resp, d_resp, pmem_read, pmem_write, err;
  logic [ADDR_W-1:0] pmem_address;

  logic [LINE_W-1:0] p_i_rdata, p_d_rdata, p_pmem_wdata;
  logic              p_i_resp, p_d_resp, p_pmem_read, p_pmem_write, p_err;
  logic [ADDR_W-1:0] p_pmem_address;

  int tests  = 0;
  int errors = 0;

  logic [LINE_W-1:0] line_a5;
  logic [LINE_W-1:0] line_1234;

  always #5 clk = ~clk;

  pmem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .RR_EN(1), .WDOG_CYCLES(WDOG)) u_dut (
    .clk(clk), .rst(rst),
    .i_address(i_address), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_address(pmem_address), .pmem_rdata(pmem_rdata), .pmem_wdata(pmem_wdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
    .err(err)
  );

  // D-priority variant sharing the same stimulus.
  pmem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .RR_EN(0), .WDOG_CYCLES(WDOG)) u_dut_prio (
    .clk(clk), .rst(rst),
    .i_address(i_address), .i_read(i_read), .i_rdata(p_i_rdata), .i_resp(p_i_resp),
    .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(p_d_rdata), .d_resp(p_d_resp),
    .pmem_address(p_pmem_address), .pmem_rdata(pmem_rdata), .pmem_wdata(p_pmem_wdata),
    .pmem_read(p_pmem_read), .pmem_write(p_pmem_write), .pmem_resp(pmem_resp),
    .err(p_err)
  );

  task automatic check(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    i_address  = '0;
    i_read     = 1'b0;
    d_address  = '0;
    d_read     = 1'b0;
    d_write    = 1'b0;
    d_wdata    = '0;
    pmem_rdata = '0;
    pmem_resp  = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    line_a5   = {32{8'hA5}};
    line_1234 = {8{32'h1234_5678}};
    clear_inputs();
    rst = 1'b0;

    // Reset state
    tick();
    check("rst_pmem_read", pmem_read, 0);
    check("rst_pmem_write", pmem_write, 0);
    check("rst_pmem_address", pmem_address, 0);
    check("rst_pmem_wdata", pmem_wdata, 0);
    check("rst_resp", {i_resp, d_resp}, 0);
    check("rst_err", err, 0);
    rst = 1'b1;
    tick();

    // Single I read, memory answers on the 10th busy cycle
    i_address = 32'h0000_1040;
    i_read    = 1'b1;
    tick();
    check("i_grant_read", pmem_read, 1);
    check("i_grant_write", pmem_write, 0);
    check("i_grant_addr", pmem_address, 32'h0000_1040);
    repeat (9) tick();
    check("i_wait_read", pmem_read, 1);
    check("i_wait_resp", i_resp, 0);
    pmem_rdata = line_a5;
    pmem_resp  = 1'b1;
    #1;
    check("i_resp", i_resp, 1);
    check("i_rdata", i_rdata, line_a5);
    check("i_no_d_resp", d_resp, 0);
    tick();
    pmem_resp = 1'b0;
    #1;
    check("i_gap_resp", i_resp, 0);
    check("i_gap_read", pmem_read, 0);
    i_read = 1'b0;
    tick();
    check("i_sticky_idle", pmem_read, 0);
    tick();
    check("i_sticky_after", pmem_read, 0);

    // D writeback (read also high: write wins), outputs independent of inputs
    d_address = 32'h8000_0020;
    d_wdata   = line_1234;
    d_write   = 1'b1;
    d_read    = 1'b1;
    tick();
    check("d_grant_write", pmem_write, 1);
    check("d_grant_read", pmem_read, 0);
    check("d_grant_addr", pmem_address, 32'h8000_0020);
    check("d_grant_wdata", pmem_wdata, line_1234);
    d_wdata   = '1;
    d_address = 32'h0;
    tick();
    check("d_hold_addr", pmem_address, 32'h8000_0020);
    check("d_hold_wdata", pmem_wdata, line_1234);
    repeat (3) tick();
    pmem_resp = 1'b1;
    #1;
    check("d_resp", d_resp, 1);
    check("d_no_i_resp", i_resp, 0);
    tick();
    pmem_resp = 1'b0;
    d_write   = 1'b0;
    d_read    = 1'b0;
    #1;
    check("d_done_write", pmem_write, 0);
    tick();

    // Simultaneous requests: RR alternates I,D,I,D; D-priority always D
    do_reset();
    i_address = 32'h0000_0100;
    d_address = 32'h0000_0200;
    i_read    = 1'b1;
    d_read    = 1'b1;
    tick();
    for (int g = 0; g < 4; g++) begin
      check("rr_read", pmem_read, 1);
      check("rr_addr", pmem_address, (g % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200);
      check("prio_addr", p_pmem_address, 32'h0000_0200);
      pmem_resp = 1'b1;
      #1;
      check("rr_i_resp", i_resp, (g % 2 == 0) ? 1 : 0);
      check("rr_d_resp", d_resp, (g % 2 == 0) ? 0 : 1);
      check("prio_d_resp", {p_i_resp, p_d_resp}, 2'b01);
      tick();
      pmem_resp = 1'b0;
      if (g == 3) begin
        i_read = 1'b0;
        d_read = 1'b0;
      end
      #1;
      check("rr_gap_read", pmem_read, 0);
      tick();
      check("rr_idle_read", pmem_read, 0);
      tick();
    end
    check("rr_end_read", pmem_read, 0);

    // Watchdog: no response, err on 16th busy cycle, late resp still completes
    do_reset();
    i_address = 32'h0000_4000;
    i_read    = 1'b1;
    tick();
    repeat (14) tick();
    check("wdog_cycle15_err", err, 0);
    tick();
    check("wdog_cycle16_err", err, 1);
    check("wdog_still_read", pmem_read, 1);
    repeat (20) tick();
    check("wdog_sat_err", err, 1);
    pmem_resp = 1'b1;
    #1;
    check("wdog_late_resp", i_resp, 1);
    tick();
    pmem_resp = 1'b0;
    i_read    = 1'b0;
    #1;
    check("wdog_err_sticky", err, 1);
    check("wdog_done_read", pmem_read, 0);
    tick();

    // Reset in the middle of a D transaction
    d_address = 32'h8000_0040;
    d_write   = 1'b1;
    tick();
    check("mid_write", pmem_write, 1);
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_write", pmem_write, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_addr", pmem_address, 0);
    d_write = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("post_rst_idle", {pmem_read, pmem_write}, 0);
    pmem_resp = 1'b1;
    #1;
    check("stray_resp", {i_resp, d_resp}, 0);
    tick();
    pmem_resp = 1'b0;
    i_address = 32'h0000_2000;
    i_read    = 1'b1;
    tick();
    check("post_rst_grant", pmem_read, 1);
    check("post_rst_addr", pmem_address, 32'h0000_2000);
    pmem_resp = 1'b1;
    #1;
    check("post_rst_resp", i_resp, 1);
    tick();
    pmem_resp = 1'b0;
    i_read    = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
